// File: rtl/paddle_step_sched_pkg.sv
// Shared definitions for the paddle step scheduler.
// Contents:
//   sched_state_e       scheduler FSM encoding (idle / issue / cooldown gap)
//   DIR_LEFT/DIR_RIGHT  encoding of upd_dir
//   PLAYER_0/PLAYER_1   encoding of upd_player
package paddle_step_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StGap   = 2'd2
  } sched_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic PLAYER_0 = 1'b0;
  localparam logic PLAYER_1 = 1'b1;

endpackage

// File: rtl/paddle_step_sched_if.sv
// Paddle update command channel (valid/ready).
// Signals:
//   upd_valid   command valid (scheduler -> game state)
//   upd_ready   command accepted (game state -> scheduler)
//   upd_player  player the command applies to
//   upd_dir     0 = left (-1), 1 = right (+1)
// Modports: master = scheduler side, slave = game-state side.
interface paddle_step_sched_if;

  logic upd_valid;
  logic upd_ready;
  logic upd_player;
  logic upd_dir;

  modport master (
    output upd_valid,
    output upd_player,
    output upd_dir,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_player,
    input  upd_dir,
    output upd_ready
  );

endinterface

// File: rtl/paddle_step_sched_step_accum.sv
// Per-player saturating signed pending-step counter.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   left, right  one-cycle step pulses (same cycle cancels)
//   drain_en     an accepted command for this player removes one step
//   drain_dir    direction of that command (right drains -1, left drains +1)
//   clr          discard the current count (step blocked at a bound)
//   pend         current signed count, limited to +/-(2^(CNT_W-1)-1)
module paddle_step_sched_step_accum
  import paddle_step_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    left,
  input  logic                    right,
  input  logic                    drain_en,
  input  logic                    drain_dir,
  input  logic                    clr,
  output logic signed [CNT_W-1:0] pend
);

  // Two guard bits so base + pulse + drain can never overflow before clamping.
  localparam int unsigned SumW = CNT_W + 2;
  localparam logic signed [SumW-1:0] PendMax  = SumW'((1 << (CNT_W - 1)) - 1);
  localparam logic signed [SumW-1:0] PendMin  = -PendMax;
  localparam logic signed [SumW-1:0] One      = SumW'(1);
  localparam logic signed [SumW-1:0] MinusOne = -One;

  logic signed [CNT_W-1:0] pend_q, pend_d;
  logic signed [SumW-1:0]  base, step_in, step_drain, sum;

  always_comb begin
    base       = clr ? '0 : {{2{pend_q[CNT_W-1]}}, pend_q};
    step_in    = '0;
    step_drain = '0;
    if (right && !left) begin
      step_in = One;
    end else if (left && !right) begin
      step_in = MinusOne;
    end
    if (drain_en) begin
      step_drain = (drain_dir == DIR_RIGHT) ? MinusOne : One;
    end
    sum = base + step_in + step_drain;
    if (sum > PendMax) begin
      pend_d = PendMax[CNT_W-1:0];
    end else if (sum < PendMin) begin
      pend_d = PendMin[CNT_W-1:0];
    end else begin
      pend_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/paddle_step_sched.sv
// Paddle step scheduler: accumulates both players' step pulses, grants the shared
// update channel round-robin with a cooldown, and tracks clamped paddle positions.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   p0_left/p0_right        player 0 step pulses
//   p1_left/p1_right        player 1 step pulses
//   upd                     update command channel (master side)
//   p0_pos, p1_pos          paddle positions, always within 0..POS_MAX
//   p0_drop_cnt/p1_drop_cnt steps dropped at a bound (only with PADDLE_SCHED_STATS_EN)
//   busy                    high whenever the FSM is not idle
// Optional build macro: PADDLE_SCHED_STATS_EN.
module paddle_step_sched
  import paddle_step_sched_pkg::*;
#(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned POS_W    = 8,
  parameter int unsigned POS_MAX  = 200,
  parameter int unsigned POS_INIT = 100,
  parameter int unsigned GAP_CYC  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p0_left,
  input  logic             p0_right,
  input  logic             p1_left,
  input  logic             p1_right,
  paddle_step_sched_if.master upd,
  output logic [POS_W-1:0] p0_pos,
  output logic [POS_W-1:0] p1_pos,
`ifdef PADDLE_SCHED_STATS_EN
  output logic [15:0]      p0_drop_cnt,
  output logic [15:0]      p1_drop_cnt,
`endif
  output logic             busy
);

  localparam logic [POS_W-1:0] PosMax  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] PosInit = POS_W'(POS_INIT);
  // Gap counter holds GAP_CYC-1 down to 0.
  localparam int unsigned      GapW    = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam logic [GapW-1:0]  GapLoad = GapW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  sched_state_e            state_q;
  logic                    upd_valid_q, upd_player_q, upd_dir_q;
  logic                    last_q;  // player granted most recently
  logic [POS_W-1:0]        p0_pos_q, p1_pos_q;
  logic [GapW-1:0]         gap_q;

  logic signed [CNT_W-1:0] pend0, pend1;
  logic                    want0, want1, dir0, dir1, room0, room1;
  logic                    elig0, elig1, clr0, clr1;
  logic                    grant_any, win;
  logic                    hs, drain0, drain1;

  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos, input logic dir);
    if (dir == DIR_RIGHT) begin
      return (pos < PosMax) ? pos + POS_W'(1) : pos;
    end
    return (pos != '0) ? pos - POS_W'(1) : pos;
  endfunction

  assign hs     = upd_valid_q && upd.upd_ready;
  assign drain0 = hs && (upd_player_q == PLAYER_0);
  assign drain1 = hs && (upd_player_q == PLAYER_1);

  always_comb begin
    want0 = (pend0 != '0);
    want1 = (pend1 != '0);
    dir0  = pend0[CNT_W-1] ? DIR_LEFT : DIR_RIGHT;
    dir1  = pend1[CNT_W-1] ? DIR_LEFT : DIR_RIGHT;
    room0 = (dir0 == DIR_RIGHT) ? (p0_pos_q < PosMax) : (p0_pos_q != '0);
    room1 = (dir1 == DIR_RIGHT) ? (p1_pos_q < PosMax) : (p1_pos_q != '0);
    elig0 = (state_q == StIdle) && want0 && room0;
    elig1 = (state_q == StIdle) && want1 && room1;
    // A step pointing past a bound can never be issued, so it is discarded.
    clr0  = (state_q == StIdle) && want0 && !room0;
    clr1  = (state_q == StIdle) && want1 && !room1;
    grant_any = elig0 || elig1;
    win       = (elig0 && elig1) ? ~last_q : elig1;
  end

  paddle_step_sched_step_accum #(
    .CNT_W(CNT_W)
  ) u_step_accum_p0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .left     (p0_left),
    .right    (p0_right),
    .drain_en (drain0),
    .drain_dir(upd_dir_q),
    .clr      (clr0),
    .pend     (pend0)
  );

  paddle_step_sched_step_accum #(
    .CNT_W(CNT_W)
  ) u_step_accum_p1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .left     (p1_left),
    .right    (p1_right),
    .drain_en (drain1),
    .drain_dir(upd_dir_q),
    .clr      (clr1),
    .pend     (pend1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      upd_valid_q  <= 1'b0;
      upd_player_q <= PLAYER_0;
      upd_dir_q    <= DIR_LEFT;
      last_q       <= PLAYER_1;  // player 0 wins the first tie
      p0_pos_q     <= PosInit;
      p1_pos_q     <= PosInit;
      gap_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            state_q      <= StIssue;
            upd_valid_q  <= 1'b1;
            upd_player_q <= win;
            upd_dir_q    <= win ? dir1 : dir0;
            last_q       <= win;
          end
        end
        StIssue: begin
          if (upd.upd_ready) begin
            upd_valid_q <= 1'b0;
            if (upd_player_q == PLAYER_0) begin
              p0_pos_q <= step_pos(p0_pos_q, upd_dir_q);
            end else begin
              p1_pos_q <= step_pos(p1_pos_q, upd_dir_q);
            end
            if (GAP_CYC > 0) begin
              state_q <= StGap;
              gap_q   <= GapLoad;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StGap: begin
          if (gap_q == '0) begin
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q - GapW'(1);
          end
        end
        default: begin
          state_q     <= StIdle;
          upd_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PADDLE_SCHED_STATS_EN
  logic [15:0] drop0_q, drop1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop0_q <= '0;
      drop1_q <= '0;
    end else begin
      if (clr0 && (drop0_q != 16'hFFFF)) begin
        drop0_q <= drop0_q + 16'd1;
      end
      if (clr1 && (drop1_q != 16'hFFFF)) begin
        drop1_q <= drop1_q + 16'd1;
      end
    end
  end

  assign p0_drop_cnt = drop0_q;
  assign p1_drop_cnt = drop1_q;
`endif

  assign upd.upd_valid  = upd_valid_q;
  assign upd.upd_player = upd_player_q;
  assign upd.upd_dir    = upd_dir_q;
  assign p0_pos         = p0_pos_q;
  assign p1_pos         = p1_pos_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_paddle_step_sched.sv
// Directed testbench for paddle_step_sched (default parameters, GAP_CYC = 4).
module tb_paddle_step_sched;

  logic       clk;
  logic       rst_n;
  logic       p0_left, p0_right, p1_left, p1_right;
  logic [7:0] p0_pos, p1_pos;
  logic       busy;
`ifdef PADDLE_SCHED_STATS_EN
  logic [15:0] p0_drop_cnt, p1_drop_cnt;
`endif

  paddle_step_sched_if upd_if ();

  paddle_step_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p0_left    (p0_left),
    .p0_right   (p0_right),
    .p1_left    (p1_left),
    .p1_right   (p1_right),
    .upd        (upd_if),
    .p0_pos     (p0_pos),
    .p1_pos     (p1_pos),
`ifdef PADDLE_SCHED_STATS_EN
    .p0_drop_cnt(p0_drop_cnt),
    .p1_drop_cnt(p1_drop_cnt),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Accepted handshakes as {player, dir}, sampled mid-cycle.
  logic [1:0] hs_q[$];
  always @(negedge clk) begin
    if (rst_n && upd_if.upd_valid && upd_if.upd_ready) begin
      hs_q.push_back({upd_if.upd_player, upd_if.upd_dir});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      if (upd_if.upd_valid) ok = 1'b1;
      else tick();
    end
  endtask

  bit ok;
  bit seen;
  bit exp_p [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    rst_n = 1'b0;
    p0_left = 1'b0; p0_right = 1'b0; p1_left = 1'b0; p1_right = 1'b0;
    upd_if.upd_ready = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst_valid", upd_if.upd_valid, 0);
    check("rst_player", upd_if.upd_player, 0);
    check("rst_dir", upd_if.upd_dir, 0);
    check("rst_busy", busy, 0);
    check("rst_p0_pos", p0_pos, 100);
    check("rst_p1_pos", p1_pos, 100);
    rst_n = 1'b1;

    // Single p0_right: latency t+2, position step, 4 gap cycles
    upd_if.upd_ready = 1'b1;
    p0_right = 1'b1;
    tick();
    p0_right = 1'b0;
    check("t1_valid_t1", upd_if.upd_valid, 0);
    tick();
    check("t1_valid_t2", upd_if.upd_valid, 1);
    check("t1_player", upd_if.upd_player, 0);
    check("t1_dir", upd_if.upd_dir, 1);
    check("t1_pos_before", p0_pos, 100);
    tick();
    check("t1_pos_after", p0_pos, 101);
    check("t1_valid_gap", upd_if.upd_valid, 0);
    for (int i = 0; i < 4; i++) begin
      check("t1_busy_gap", busy, 1);
      tick();
    end
    check("t1_busy_idle", busy, 0);

    // Round-robin: 3x p0_right with 5x p1_left
    do_reset();
    hs_q.delete();
    upd_if.upd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      p1_left  = 1'b1;
      p0_right = (i < 3);
      tick();
    end
    p1_left  = 1'b0;
    p0_right = 1'b0;
    repeat (80) tick();
    check("t2_grant_count", hs_q.size(), 8);
    for (int i = 0; i < 8 && i < hs_q.size(); i++) begin
      check("t2_grant", {30'd0, hs_q[i]}, {30'd0, exp_p[i], ~exp_p[i]});
    end
    check("t2_p0_pos", p0_pos, 103);
    check("t2_p1_pos", p1_pos, 95);

    // Back-pressure: command held stable while ready is low
    do_reset();
    upd_if.upd_ready = 1'b0;
    p1_right = 1'b1;
    tick();
    p1_right = 1'b0;
    wait_valid(10, ok);
    check("t3_valid_seen", ok, 1);
    for (int i = 0; i < 6; i++) begin
      check("t3_hold_valid", upd_if.upd_valid, 1);
      check("t3_hold_player", upd_if.upd_player, 1);
      check("t3_hold_dir", upd_if.upd_dir, 1);
      check("t3_hold_pos", p1_pos, 100);
      tick();
    end
    upd_if.upd_ready = 1'b1;
    tick();
    check("t3_pos_after", p1_pos, 101);
    check("t3_valid_after", upd_if.upd_valid, 0);

    // Upper bound: walk p0 to 200, then a right step must be dropped
    do_reset();
    upd_if.upd_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      p0_right = 1'b1;
      tick();
      p0_right = 1'b0;
      repeat (8) tick();
    end
    check("t4_pos_max", p0_pos, 200);
    hs_q.delete();
    p0_right = 1'b1;
    tick();
    p0_right = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (upd_if.upd_valid) seen = 1'b1;
      tick();
    end
    check("t4_no_valid", seen, 0);
    check("t4_pos_held", p0_pos, 200);
`ifdef PADDLE_SCHED_STATS_EN
    check("t4_drop0", p0_drop_cnt, 1);
    check("t4_drop1", p1_drop_cnt, 0);
`endif
    // A cleared count means a single left pulse yields exactly one step
    p0_left = 1'b1;
    tick();
    p0_left = 1'b0;
    repeat (10) tick();
    check("t4_left_steps", hs_q.size(), 1);
    check("t4_pos_left", p0_pos, 199);

    // Saturation: 10 pulses while stalled issue exactly 7 steps
    do_reset();
    hs_q.delete();
    upd_if.upd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      p0_right = 1'b1;
      tick();
    end
    p0_right = 1'b0;
    upd_if.upd_ready = 1'b1;
    repeat (70) tick();
    check("t5_step_count", hs_q.size(), 7);
    check("t5_p0_pos", p0_pos, 107);
    for (int i = 0; i < hs_q.size(); i++) begin
      check("t5_step_cmd", {30'd0, hs_q[i]}, 32'd1);
    end

    // Reset while a command is stalled in issue
    do_reset();
    upd_if.upd_ready = 1'b0;
    p0_right = 1'b1;
    tick();
    p0_right = 1'b0;
    wait_valid(10, ok);
    check("t6_valid_seen", ok, 1);
    rst_n = 1'b0;
    tick();
    check("t6_valid_rst", upd_if.upd_valid, 0);
    check("t6_busy_rst", busy, 0);
    check("t6_p0_pos", p0_pos, 100);
    check("t6_p1_pos", p1_pos, 100);
    rst_n = 1'b1;
    upd_if.upd_ready = 1'b1;
    hs_q.delete();
    repeat (10) tick();
    check("t6_no_steps", hs_q.size(), 0);
    check("t6_p0_pos_end", p0_pos, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/paddle_step_sched.md
Name: paddle_step_sched

Overview:
- Sits between the two per-player dip-switch decoders and the game-state paddle update port.
- Accumulates each player's left/right step pulses as a signed net count.
- Arbitrates round-robin between the two players for the single shared update port, and rate-limits grants with a cooldown.
- Tracks both paddle positions, clamped to the legal range.

Parameters:
- CNT_W, 4: width of the signed per-player pending-step counter. It saturates at ±(2^(CNT_W-1)-1).
- POS_W, 8: paddle position width.
- POS_MAX, 200: highest legal paddle position. The lowest is 0.
- POS_INIT, 100: paddle position after reset.
- GAP_CYC, 4: cooldown cycles after each accepted update. 0 means no cooldown.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- p0_left  in  1  player 0 one-cycle left-step pulse.
- p0_right  in  1  player 0 one-cycle right-step pulse.
- p1_left  in  1  player 1 one-cycle left-step pulse.
- p1_right  in  1  player 1 one-cycle right-step pulse.
- upd_valid  out  1  step command valid.
- upd_ready  in  1  downstream accepts the command.
- upd_player  out  1  player of the current command.
- upd_dir  out  1  direction of the current command: 0 = left (-1), 1 = right (+1).
- p0_pos  out  POS_W  player 0 paddle position.
- p1_pos  out  POS_W  player 1 paddle position.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n = 0 at a clk edge), including mid-operation:
  - state = IDLE; pending counters = 0; p0_pos = p1_pos = POS_INIT.
  - upd_valid = 0, upd_player = 0, upd_dir = 0, busy = 0.
  - Round-robin pointer set so player 0 wins the first tie.
  - An in-flight command is abandoned, with no position change.
- Pending counter update, every cycle, per player:
  - pend_next = sat(pend + right - left - drain).
  - drain = +1 or -1 only on an accepted handshake for that player, matching upd_dir; otherwise 0.
  - left and right in the same cycle cancel.
  - Saturation clamps to ±(2^(CNT_W-1)-1) and never wraps.
- Eligibility, evaluated in IDLE only:
  - A player is eligible if pend != 0 and the step direction (sign of pend) keeps the position within 0..POS_MAX.
  - If pend != 0 but the paddle is at the bound in that direction, pend is cleared to 0 that cycle and the step is dropped.
- States:
  - IDLE: if any player is eligible, latch the winner into upd_player and upd_dir = (pend > 0), then go to ISSUE. If both are eligible, grant the player not granted last, and the pointer updates on grant.
  - ISSUE: upd_valid = 1. upd_player and upd_dir are held stable while upd_valid && !upd_ready. On upd_valid && upd_ready:
    - the position is updated ±1 at that edge;
    - pend is drained by one;
    - next state is GAP if GAP_CYC > 0, else IDLE.
    - Pulses arriving during ISSUE still accumulate. A latched step completes even if new pulses reverse the sign of pend.
  - GAP: counter runs GAP_CYC cycles with upd_valid = 0, then IDLE.
- Latency:
  - Pulse in cycle t → pend updated at edge t+1 → IDLE decision → upd_valid = 1 in cycle t+2.
  - Back-to-back grants with GAP_CYC = G and ready tied high are separated by G + 2 cycles.
- Positions never leave 0..POS_MAX under any stimulus.

Optional Feature:
- Macro PADDLE_SCHED_STATS_EN.
- When defined:
  - Adds outputs p0_drop_cnt and p1_drop_cnt, each 16 bits and reset to 0.
  - Each increments by 1 per bound-clear event, saturating at 0xFFFF.
- When undefined:
  - The ports and counters do not exist.
  - All other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, ISSUE, GAP;
  - direction constants: DIR_LEFT = 0, DIR_RIGHT = 1;
  - player index constants.
- Sub-module step_accum: one per player (two instances). It contains the saturating signed pending counter with inputs left, right, drain_en, drain_dir, clr.

Test Plan:
- Reset, then a single p0_right pulse with ready = 1 and GAP_CYC = 4 → upd_valid in cycle t+2 with player = 0, dir = 1; p0_pos changes 100 → 101; busy then stays high for 4 GAP cycles.
- Five p1_left pulses plus three p0_right pulses in the same cycles, ready = 1 → grants alternate P0, P1, P0, P1, P0, P1, P1, P1; final p0_pos = 103, p1_pos = 95.
- Hold upd_ready = 0 for 6 cycles during ISSUE → upd_valid, upd_player and upd_dir are stable all 6 cycles; the position is unchanged until the handshake.
- Drive p0_pos to 200, then one p0_right pulse → no upd_valid; pend cleared; p0_drop_cnt = 1 when the macro is defined.
- Ten consecutive p0_right pulses with ready = 0 → pend saturates at +7 and does not wrap; after release, exactly 7 steps are issued.
- Assert rst_n = 0 while in ISSUE with ready = 0 → upd_valid = 0 next cycle; positions = 100; pend = 0.
